// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline: load-use, branch-in-ID deps, dmem waits.
// Optional performance counters are built only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       AA,
  input  logic [4:0]       BA,
  input  logic             USE_A,
  input  logic             USE_B,
  input  logic             BR,
  input  logic             BR_TAKEN,
  input  logic [4:0]       ID_EX_DA,
  input  logic             ID_EX_RW,
  input  logic             ID_EX_MR,
  input  logic [4:0]       EX_MEM_DA,
  input  logic             EX_MEM_MR,
  input  logic             DMEM_REQ,
  input  logic             DMEM_ACK,
  output logic             PC_WE,
  output logic             IF_ID_WE,
  output logic             ID_EX_WE,
  output logic             EX_MEM_WE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             MEM_WB_FLUSH,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT,
  output logic [CNT_W-1:0] MWAIT_CNT
);

  typedef enum logic [1:0] {RUN, MWAIT, HALT} state_t;

  localparam logic [7:0] WLAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;

  logic m_a, m_b, hit_ex, hit_mem;
  logic load_use, br_dep, dstall, freeze, br_flush;

  // x0 is hardwired zero, so it never creates a dependency
  assign m_a      = USE_A & (AA != 5'd0);
  assign m_b      = USE_B & (BA != 5'd0);
  assign hit_ex   = ((ID_EX_DA == AA) & m_a) | ((ID_EX_DA == BA) & m_b);
  assign hit_mem  = ((EX_MEM_DA == AA) & m_a) | ((EX_MEM_DA == BA) & m_b);
  assign load_use = ID_EX_MR & hit_ex;
  assign br_dep   = BR & ((ID_EX_RW & hit_ex) | (EX_MEM_MR & hit_mem));
  assign dstall   = load_use | br_dep;
  assign freeze   = DMEM_REQ & ~DMEM_ACK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: begin
        wcnt_nxt = 8'd0;
        if (freeze) begin
          state_nxt = MWAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MWAIT: begin
        if (!freeze) begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end else if (wcnt == WLAST) begin
          state_nxt = HALT;
          wcnt_nxt  = 8'd0;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      HALT:    wcnt_nxt = 8'd0;
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
  end

  // Priority: reset/halt > dmem freeze > data stall > taken branch > run
  always_comb begin
    PC_WE        = 1'b1;
    IF_ID_WE     = 1'b1;
    ID_EX_WE     = 1'b1;
    EX_MEM_WE    = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    MEM_WB_FLUSH = 1'b0;
    br_flush     = 1'b0;
    if (rst || state == HALT) begin
      PC_WE        = 1'b0;
      IF_ID_WE     = 1'b0;
      ID_EX_WE     = 1'b0;
      EX_MEM_WE    = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      MEM_WB_FLUSH = 1'b1;
    end else if (freeze) begin
      PC_WE        = 1'b0;
      IF_ID_WE     = 1'b0;
      ID_EX_WE     = 1'b0;
      EX_MEM_WE    = 1'b0;
      MEM_WB_FLUSH = 1'b1;
    end else if (dstall) begin
      PC_WE       = 1'b0;
      IF_ID_WE    = 1'b0;
      ID_EX_FLUSH = 1'b1;
    end else if (BR_TAKEN) begin
      IF_ID_FLUSH = 1'b1;
      br_flush    = 1'b1;
    end
  end

  assign MEM_ERR = (state == HALT) & ~rst;

`ifdef HAZARD_CTRL_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] stall_cnt, flush_cnt, mwait_cnt;
  logic             live;

  assign live = ~rst & (state != HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      mwait_cnt <= '0;
    end else begin
      if (live & dstall & ~freeze) stall_cnt <= sat_inc(stall_cnt);
      if (live & br_flush)         flush_cnt <= sat_inc(flush_cnt);
      if (live & freeze)           mwait_cnt <= sat_inc(mwait_cnt);
    end
  end

  assign STALL_CNT = stall_cnt;
  assign FLUSH_CNT = flush_cnt;
  assign MWAIT_CNT = mwait_cnt;
`else
  assign STALL_CNT = '0;
  assign FLUSH_CNT = '0;
  assign MWAIT_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a negedge monitor checks them.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [4:0] AA, BA, ID_EX_DA, EX_MEM_DA;
  logic USE_A, USE_B, BR, BR_TAKEN, ID_EX_RW, ID_EX_MR, EX_MEM_MR, DMEM_REQ, DMEM_ACK;
  logic PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE;
  logic IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, MEM_ERR;
  logic [31:0] STALL_CNT, FLUSH_CNT, MWAIT_CNT;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .AA(AA), .BA(BA), .USE_A(USE_A), .USE_B(USE_B),
    .BR(BR), .BR_TAKEN(BR_TAKEN), .ID_EX_DA(ID_EX_DA), .ID_EX_RW(ID_EX_RW),
    .ID_EX_MR(ID_EX_MR), .EX_MEM_DA(EX_MEM_DA), .EX_MEM_MR(EX_MEM_MR),
    .DMEM_REQ(DMEM_REQ), .DMEM_ACK(DMEM_ACK), .PC_WE(PC_WE), .IF_ID_WE(IF_ID_WE),
    .ID_EX_WE(ID_EX_WE), .EX_MEM_WE(EX_MEM_WE), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_FLUSH(ID_EX_FLUSH), .MEM_WB_FLUSH(MEM_WB_FLUSH), .MEM_ERR(MEM_ERR),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT), .MWAIT_CNT(MWAIT_CNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  we;
    logic [2:0]  fl;
    logic        err;
    bit          chk;
    logic [31:0] s, f, m;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // WE order {PC, IF_ID, ID_EX, EX_MEM}; flush order {IF_ID, ID_EX, MEM_WB}
  localparam logic [3:0] WE_ALL = 4'b1111, WE_NONE = 4'b0000, WE_STL = 4'b0011;
  localparam logic [2:0] FL_NONE = 3'b000, FL_ALL = 3'b111, FL_MWB = 3'b001,
                         FL_IDEX = 3'b010, FL_IFID = 3'b100;

  task automatic clr();
    rst = 0; AA = 0; BA = 0; USE_A = 0; USE_B = 0; BR = 0; BR_TAKEN = 0;
    ID_EX_DA = 0; ID_EX_RW = 0; ID_EX_MR = 0; EX_MEM_DA = 0; EX_MEM_MR = 0;
    DMEM_REQ = 0; DMEM_ACK = 0;
  endtask

  task automatic step(input string name, input logic [3:0] we, input logic [2:0] fl,
                      input logic err, input bit chk = 0,
                      input int s = 0, input int f = 0, input int m = 0);
    exp_t e;
    e.name = name; e.we = we; e.fl = fl; e.err = err; e.chk = chk;
    e.s = PERF ? 32'(s) : 32'd0;
    e.f = PERF ? 32'(f) : 32'd0;
    e.m = PERF ? 32'(m) : 32'd0;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE} !== e.we) begin
          failures++;
          $display("FAIL %s we got=%b exp=%b", e.name, {PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE}, e.we);
        end
        checks++;
        if ({IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH} !== e.fl) begin
          failures++;
          $display("FAIL %s flush got=%b exp=%b", e.name, {IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH}, e.fl);
        end
        checks++;
        if (MEM_ERR !== e.err) begin
          failures++;
          $display("FAIL %s mem_err got=%b exp=%b", e.name, MEM_ERR, e.err);
        end
        if (e.chk) begin
          checks++;
          if (STALL_CNT !== e.s) begin
            failures++;
            $display("FAIL %s stall_cnt got=%0d exp=%0d", e.name, STALL_CNT, e.s);
          end
          checks++;
          if (FLUSH_CNT !== e.f) begin
            failures++;
            $display("FAIL %s flush_cnt got=%0d exp=%0d", e.name, FLUSH_CNT, e.f);
          end
          checks++;
          if (MWAIT_CNT !== e.m) begin
            failures++;
            $display("FAIL %s mwait_cnt got=%0d exp=%0d", e.name, MWAIT_CNT, e.m);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    clr();
    rst = 1;
    @(posedge clk);
    #1;
    step("reset", WE_NONE, FL_ALL, 1'b0);
    clr();
    step("post_reset", WE_ALL, FL_NONE, 1'b0, 1, 0, 0, 0);

    clr(); ID_EX_MR = 1; ID_EX_DA = 5; AA = 5; USE_A = 1;
    step("load_use", WE_STL, FL_IDEX, 1'b0, 1, 0, 0, 0);
    clr();
    step("load_use_done", WE_ALL, FL_NONE, 1'b0, 1, 1, 0, 0);

    clr(); ID_EX_MR = 1; ID_EX_DA = 0; AA = 0; USE_A = 1;
    step("x0_ignore", WE_ALL, FL_NONE, 1'b0);
    clr(); ID_EX_MR = 1; ID_EX_DA = 9; BA = 9; USE_B = 0;
    step("use_b_off", WE_ALL, FL_NONE, 1'b0);
    clr(); ID_EX_MR = 1; ID_EX_DA = 9; BA = 9; USE_B = 1;
    step("load_use_b", WE_STL, FL_IDEX, 1'b0);

    clr(); BR = 1; AA = 7; USE_A = 1; ID_EX_MR = 1; ID_EX_RW = 1; ID_EX_DA = 7;
    step("br_load_ex", WE_STL, FL_IDEX, 1'b0);
    clr(); BR = 1; AA = 7; USE_A = 1; EX_MEM_MR = 1; EX_MEM_DA = 7; BR_TAKEN = 1;
    step("br_load_mem", WE_STL, FL_IDEX, 1'b0);
    clr(); BR = 1; AA = 7; USE_A = 1; BR_TAKEN = 1;
    step("br_taken", WE_ALL, FL_IFID, 1'b0, 1, 4, 0, 0);
    clr();
    step("after_br", WE_ALL, FL_NONE, 1'b0, 1, 4, 1, 0);

    clr(); BR = 1; AA = 3; USE_A = 1; ID_EX_RW = 1; ID_EX_DA = 3;
    step("br_alu_ex", WE_STL, FL_IDEX, 1'b0);
    clr(); BR = 1; AA = 3; USE_A = 1; EX_MEM_DA = 3;
    step("br_alu_mem", WE_ALL, FL_NONE, 1'b0);

    for (int i = 0; i < 3; i++) begin
      clr(); DMEM_REQ = 1; ID_EX_MR = 1; ID_EX_DA = 5; AA = 5; USE_A = 1;
      step("mwait", WE_NONE, FL_MWB, 1'b0);
    end
    clr(); DMEM_REQ = 1; DMEM_ACK = 1; ID_EX_MR = 1; ID_EX_DA = 5; AA = 5; USE_A = 1;
    step("ack_last_wait", WE_STL, FL_IDEX, 1'b0, 1, 5, 1, 3);
    clr();
    step("after_wait", WE_ALL, FL_NONE, 1'b0, 1, 6, 1, 3);

    for (int i = 0; i < 4; i++) begin
      clr(); DMEM_REQ = 1;
      step("timeout_wait", WE_NONE, FL_MWB, 1'b0);
    end
    clr(); DMEM_REQ = 1;
    step("halt", WE_NONE, FL_ALL, 1'b1);
    clr();
    step("halt_hold", WE_NONE, FL_ALL, 1'b1, 1, 6, 1, 7);
    clr(); rst = 1;
    step("halt_rst", WE_NONE, FL_ALL, 1'b0);
    clr();
    step("halt_cleared", WE_ALL, FL_NONE, 1'b0, 1, 0, 0, 0);

    clr(); DMEM_REQ = 1;
    step("rst_wait1", WE_NONE, FL_MWB, 1'b0);
    step("rst_wait2", WE_NONE, FL_MWB, 1'b0);
    clr(); DMEM_REQ = 1; rst = 1;
    step("rst_mid_wait", WE_NONE, FL_ALL, 1'b0);
    clr();
    step("rst_wait_run", WE_ALL, FL_NONE, 1'b0, 1, 0, 0, 0);

    clr(); DMEM_REQ = 1; DMEM_ACK = 1;
    step("same_cycle_ack", WE_ALL, FL_NONE, 1'b0);
    clr();
    step("no_mwait", WE_ALL, FL_NONE, 1'b0, 1, 0, 0, 0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
